// File: rtl/axis_i2c_pkg.sv
// Shared types and tdata field positions for the AXIS-to-I2C write engine.
package axis_i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} i2c_state_t;
  typedef logic [1:0] quarter_t;

  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick: one-cycle pulse every DIV clk cycles while en is high.
// Latency DIV cycles from en rising to the first tick; no backpressure, counter clears whenever en is low.
module i2c_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic arstn,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/axis_i2c_wr_master.sv
// One AXIS word -> one I2C write (START, addr+W, ACK, data, ACK, STOP), open-drain outputs.
// Latency 78*DIV cycles per word (42*DIV on address NACK); s_axis_tready stays low while a word is in flight.
module axis_i2c_wr_master
  import axis_i2c_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int I2C_FREQ        = 100_000,
  parameter int AXIS_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       sda_i,
  output logic                       sda_oe,
  output logic                       scl_oe,
  output logic                       busy,
  output logic                       nack
);
  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "axis_i2c_wr_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
  end
  if (AXIS_DATA_WIDTH != 16) begin : g_bad_width
    $fatal(1, "axis_i2c_wr_master: only 16-bit tdata is supported");
  end

  i2c_state_t state;
  quarter_t   q;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] data_byte;
  logic       nack_seen;
  logic       sda_meta, sda_sync;
  logic       tick;
  logic       unused_tdata;

  assign unused_tdata = s_axis_tdata[AXIS_DATA_WIDTH-1];

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .arstn(arstn),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= IDLE;
      q             <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      data_byte     <= '0;
      nack_seen     <= 1'b0;
      sda_oe        <= 1'b0;
      scl_oe        <= 1'b0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      nack          <= 1'b0;
    end else begin
      nack <= 1'b0;
      if (state == IDLE) begin
        s_axis_tready <= 1'b1;
        if (s_axis_tvalid && s_axis_tready) begin
          shreg         <= {s_axis_tdata[ADDR_MSB:ADDR_LSB], 1'b0};
          data_byte     <= s_axis_tdata[DATA_MSB:0];
          s_axis_tready <= 1'b0;
          busy          <= 1'b1;
          nack_seen     <= 1'b0;
          q             <= '0;
          state         <= START;
          scl_oe        <= 1'b0;
          sda_oe        <= 1'b1;
        end
      end else if (tick) begin
        q <= q + 2'd1;
        case (state)
          START: begin
            if (q == 2'd1) begin
              state   <= ADDR;
              q       <= '0;
              bit_cnt <= '0;
              scl_oe  <= 1'b1;
              sda_oe  <= ~shreg[7];
            end
          end
          STOP: begin
            case (q)
              2'd1: scl_oe <= 1'b0;
              2'd2: sda_oe <= 1'b0;
              2'd3: begin
                state         <= IDLE;
                busy          <= 1'b0;
                s_axis_tready <= 1'b1;
              end
              default: ;
            endcase
          end
          default: begin
            // ADDR, ACK1, DATA, ACK2 share the SCL low-low-high-high bit shape.
            case (q)
              2'd1: scl_oe <= 1'b0;
              2'd2: begin
                if ((state == ACK1 || state == ACK2) && sda_sync) begin
                  nack      <= 1'b1;
                  nack_seen <= 1'b1;
                end
              end
              2'd3: begin
                scl_oe <= 1'b1;
                if (state == ADDR || state == DATA) begin
                  if (bit_cnt == 3'd7) begin
                    state  <= (state == ADDR) ? ACK1 : ACK2;
                    sda_oe <= 1'b0;
                  end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                    sda_oe  <= ~shreg[6];
                  end
                end else if (state == ACK1 && !nack_seen) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  shreg   <= data_byte;
                  sda_oe  <= ~data_byte[7];
                end else begin
                  state  <= STOP;
                  sda_oe <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_i2c_wr_master.sv
// Directed bench for axis_i2c_wr_master at DIV=10 with a bus monitor and an ACKing slave model.
module tb_axis_i2c_wr_master;
  logic        clk = 1'b0;
  logic        arstn;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic        sda_i;
  logic        sda_oe, scl_oe, busy, nack;

  logic slave_low = 1'b0;
  logic ack1_en = 1'b1, ack2_en = 1'b1;

  assign sda_i = ~(sda_oe | slave_low);

  axis_i2c_wr_master #(
    .CLK_FREQ(4_000_000), .I2C_FREQ(100_000), .AXIS_DATA_WIDTH(16)
  ) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .sda_i(sda_i), .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .nack(nack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor / scoreboard, sampled on the falling edge.
  int   cyc = 0;
  int   n_acc = 0, acc_cyc = 0;
  int   n_nack = 0, nack_off = -1;
  int   n_start = 0, n_stop = 0, n_rdy_busy = 0;
  int   rise_cnt = 0, cur_len = 0;
  int   frame_len = 0, frame_rises = 0;
  logic [7:0] addr_cap = '0, data_cap = '0, frame_addr = '0, frame_data = '0;
  logic scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic scl_now, sda_now;
    scl_now = ~scl_oe;
    sda_now = sda_i;
    if (scl_prev && scl_now && sda_prev && !sda_now) n_start++;
    if (scl_prev && scl_now && !sda_prev && sda_now) n_stop++;
    if (busy_prev && !busy) begin
      frame_len   = cur_len;
      frame_rises = rise_cnt;
      frame_addr  = addr_cap;
      frame_data  = data_cap;
      cur_len     = 0;
    end
    if (busy) cur_len++;
    if (!busy) rise_cnt = 0;
    if (!scl_prev && scl_now && busy) begin
      rise_cnt++;
      if (rise_cnt <= 8) addr_cap = {addr_cap[6:0], sda_now};
      else if (rise_cnt >= 10 && rise_cnt <= 17) data_cap = {data_cap[6:0], sda_now};
    end
    if (scl_prev && !scl_now)
      slave_low = (rise_cnt == 8 && ack1_en) || (rise_cnt == 17 && ack2_en);
    if (!busy) slave_low = 1'b0;
    if (nack) begin
      n_nack++;
      nack_off = cyc - acc_cyc;
    end
    if (busy && s_axis_tready) n_rdy_busy++;
    if (arstn && s_axis_tvalid && s_axis_tready) begin
      n_acc++;
      acc_cyc = cyc + 1;
    end
    scl_prev  = scl_now;
    sda_prev  = sda_now;
    busy_prev = busy;
  end

  task automatic send_word(input logic [15:0] w, output logic tmo);
    int n0;
    n0 = n_acc;
    tmo = 1'b1;
    @(posedge clk); #1;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_acc != n0) begin tmo = 1'b0; break; end
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 16'hFFFF;
  endtask

  task automatic wait_idle(output logic tmo);
    tmo = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (!busy) begin tmo = 1'b0; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] w, input logic a1, input logic a2);
    logic t1, t2;
    ack1_en = a1;
    ack2_en = a2;
    send_word(w, t1);
    wait_idle(t2);
    check_eq({tag, "_timeout"}, {30'd0, t1, t2}, 32'd0);
  endtask

  initial begin
    int s0, p0, k0, n0, a1, a2;
    logic t1, t2;
    arstn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 16'h0000;
    #23;
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_nack", nack, 0);
    @(posedge clk); #1 arstn = 1'b1;
    @(posedge clk); #1;
    check_eq("tready_after_rst", s_axis_tready, 1);

    // Plain write, both slots ACKed
    s0 = n_start; p0 = n_stop; k0 = n_nack;
    run_frame("w50a5", 16'h50A5, 1'b1, 1'b1);
    check_eq("w50a5_addr", frame_addr, 8'hA0);
    check_eq("w50a5_data", frame_data, 8'hA5);
    check_eq("w50a5_busy_len", frame_len, 780);
    check_eq("w50a5_scl_rises", frame_rises, 19);
    check_eq("w50a5_nack_cnt", n_nack - k0, 0);
    check_eq("w50a5_start_edges", n_start - s0, 1);
    check_eq("w50a5_stop_edges", n_stop - p0, 1);

    // Address NACK
    s0 = n_start; p0 = n_stop; k0 = n_nack;
    run_frame("w3c11", 16'h3C11, 1'b0, 1'b1);
    check_eq("w3c11_addr", frame_addr, 8'h78);
    check_eq("w3c11_busy_len", frame_len, 420);
    check_eq("w3c11_scl_rises", frame_rises, 10);
    check_eq("w3c11_nack_cnt", n_nack - k0, 1);
    check_eq("w3c11_nack_time", nack_off, 370);
    check_eq("w3c11_start_edges", n_start - s0, 1);
    check_eq("w3c11_stop_edges", n_stop - p0, 1);

    // Data NACK
    k0 = n_nack;
    run_frame("w50ff", 16'h50FF, 1'b1, 1'b0);
    check_eq("w50ff_data", frame_data, 8'hFF);
    check_eq("w50ff_busy_len", frame_len, 780);
    check_eq("w50ff_nack_cnt", n_nack - k0, 1);
    check_eq("w50ff_nack_time", nack_off, 730);

    // Back-to-back with tvalid held high
    ack1_en = 1'b1; ack2_en = 1'b1;
    n0 = n_acc; s0 = n_start; p0 = n_stop;
    @(posedge clk); #1;
    s_axis_tdata = 16'h5001; s_axis_tvalid = 1'b1;
    t1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_acc != n0) begin t1 = 1'b0; break; end
    end
    #1 a1 = acc_cyc; s_axis_tdata = 16'h5002;
    t2 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (n_acc == n0 + 2) begin t2 = 1'b0; break; end
    end
    #1 a2 = acc_cyc; s_axis_tvalid = 1'b0; s_axis_tdata = 16'hFFFF;
    check_eq("b2b_timeout", {30'd0, t1, t2}, 0);
    check_eq("b2b_first_data", frame_data, 8'h01);
    check_eq("b2b_accept_gap", a2 - a1, 781);
    wait_idle(t1);
    check_eq("b2b_idle_timeout", t1, 0);
    check_eq("b2b_second_data", frame_data, 8'h02);
    check_eq("b2b_accepts", n_acc - n0, 2);
    check_eq("b2b_start_edges", n_start - s0, 2);
    check_eq("b2b_stop_edges", n_stop - p0, 2);
    check_eq("tready_during_busy", n_rdy_busy, 0);

    // Reset while a data bit 0 is driven with SCL low
    send_word(16'h5033, t1);
    t2 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rise_cnt == 14 && scl_oe && sda_oe) begin t2 = 1'b0; break; end
    end
    check_eq("mid_rst_reach_data", {30'd0, t1, t2}, 0);
    check_eq("mid_rst_sda_before", sda_oe, 1);
    #2 arstn = 1'b0;
    #1;
    check_eq("mid_rst_sda_oe", sda_oe, 0);
    check_eq("mid_rst_scl_oe", scl_oe, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_tready", s_axis_tready, 0);
    #30;
    @(posedge clk); #1 arstn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_tready", s_axis_tready, 1);
    repeat (5) @(posedge clk);
    #1 check_eq("post_rst_idle", busy, 0);

    s0 = n_start; p0 = n_stop;
    run_frame("w2a55", 16'h2A55, 1'b1, 1'b1);
    check_eq("w2a55_addr", frame_addr, 8'h54);
    check_eq("w2a55_data", frame_data, 8'h55);
    check_eq("w2a55_busy_len", frame_len, 780);
    check_eq("w2a55_start_edges", n_start - s0, 1);
    check_eq("w2a55_stop_edges", n_stop - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_i2c_wr_master.md
# axis_i2c_wr_master

AXI-Stream-to-I2C write engine that sits directly downstream of the AXIS data FIFO in `axis_i2c_top`. Each 16-bit stream word is one complete I2C write transaction: START, 7-bit address with W bit, ACK slot, one data byte, ACK slot, STOP. SCL and SDA are driven open-drain. Only one word is in flight at a time, so the FIFO absorbs source bursts.

## Interface
- `CLK_FREQ`, default 50_000_000: clk frequency in Hz.
- `I2C_FREQ`, default 100_000: SCL frequency in Hz.
- `AXIS_DATA_WIDTH`, default 16: tdata width; only 16 is supported.
- `clk`  in  1  system clock.
- `arstn`  in  1  reset; asynchronous, active-low.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tready`  out  1  engine can accept a word.
- `s_axis_tdata`  in  16  [14:8] slave address, [7:0] data byte, [15] ignored.
- `sda_i`  in  1  sampled SDA line level.
- `sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `scl_oe`  out  1  1 = pull SCL low, 0 = release.
- `busy`  out  1  transaction in progress.
- `nack`  out  1  one-cycle pulse when an ACK slot samples SDA high.

## Operation
- DIV = CLK_FREQ/(4*I2C_FREQ) is elaborated as a constant; DIV < 2 is a fatal elaboration error.
- The quarter tick fires once every DIV clk cycles while not IDLE. Its counter width is $clog2(DIV), and it restarts at 0 on leaving IDLE.
- Reset values: `sda_oe`=0, `scl_oe`=0, `s_axis_tready`=0, `busy`=0, `nack`=0. State is IDLE.
- `s_axis_tready` is registered. It is 1 in IDLE from the first cycle after reset release.
- A word is accepted on `s_axis_tvalid & s_axis_tready`. On that edge the engine latches the address byte {addr,1'b0} and the data byte, sets `s_axis_tready` to 0, sets `busy` to 1, and enters START.
- States and quarter counts:
  - IDLE: waits for a word.
  - START (2 quarters): SCL released, SDA pulled low.
  - ADDR (8 bits, MSB first) -> ACK1 -> DATA (8 bits) -> ACK2 -> STOP (4 quarters) -> IDLE.
- Bit timing: q0 and q1 pull SCL low. q2 and q3 release SCL. SDA is updated at the start of q0 and held through q3. A 0 bit drives `sda_oe`=1; a 1 bit drives `sda_oe`=0.
- ACK slots release SDA. `sda_i` is sampled on the tick ending q2.
  - Sampled 1: `nack` pulses for one cycle.
  - NACK in ACK1: DATA is skipped and the engine goes straight to STOP.
  - NACK in ACK2: STOP follows as normal.
- STOP: q0 and q1 pull SCL and SDA low. q2 releases SCL with SDA still low. q3 releases SDA.
- Returning to IDLE clears `busy` and sets `s_axis_tready` in the same cycle.
- There is no clock stretching and no arbitration; `sda_i` is used only for ACK.

## Timing
- Transaction length is (2 + 36 + 36 + 4) * DIV = 78*DIV clk cycles from the accept edge to IDLE.
- A NACK on the address shortens it to 42*DIV.
- Back-to-back: with `s_axis_tvalid` held high, the next word is accepted on the first IDLE cycle. The gap between the STOP of one word and the START of the next is 1 clk plus the START phase.
- `s_axis_tdata` changes while `s_axis_tready`=0 have no effect.
- Reset mid-transaction: both lines are released asynchronously. The in-flight word is lost and is not re-requested from the FIFO.
- `sda_i` is passed through a 2-flop synchronizer, which adds 2 cycles of sample delay; DIV >= 2 makes this harmless.

## Structure
- Package `axis_i2c_pkg` holds:
  - the state enum `i2c_state_t` (IDLE, START, ADDR, ACK1, DATA, ACK2, STOP);
  - the 2-bit quarter type;
  - the tdata field localparams (ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7).
- Sub-module `i2c_tick_gen` contains the DIV counter, with inputs `clk`, `arstn`, and `en`, and output `tick`.
- The top level holds the FSM, the bit counter (0..7), the quarter counter, the shift register, and the synchronizer.

## Test plan
All scenarios use CLK_FREQ=4_000_000 and I2C_FREQ=100_000, giving DIV=10.
- Single write, tdata=16'h50A5, slave ACKs both slots:
  - SDA bits during SCL-high read 0xA0, then ACK, then 0xA5, then ACK, then STOP.
  - `busy` lasts 780 cycles and `nack` never pulses.
- Address NACK (`sda_i`=1 in ACK1) with tdata=16'h3C11:
  - `nack` pulses once on the q2 tick of ACK1.
  - No DATA clocks are issued, STOP follows, and `busy` lasts 420 cycles.
- Data NACK with tdata=16'h50FF:
  - `nack` pulses once during ACK2 and the full 780-cycle frame completes.
- Back-to-back words 16'h5001 and 16'h5002 with `tvalid` held high:
  - Exactly two accepts occur, 781 cycles apart.
  - `tready` is 0 throughout each frame.
- `arstn` asserted in mid-DATA:
  - `sda_oe` and `scl_oe` are 0 immediately.
  - After release, `tready`=1 on the next cycle and a fresh word 16'h2A55 completes correctly.
- Start-condition check:
  - SDA falls while SCL is high exactly once per frame at START.
  - SDA rises while SCL is high exactly once per frame at STOP.
  - No other SDA edge occurs while SCL is high.
